// File: rtl/alu_pipe_hs_if.sv
// Issue/writeback handshake bundle for alu_pipe_hs: operand request side plus result/flag response side.
interface alu_pipe_hs_if #(
    parameter int WIDTH  = 32,
    parameter int OP_LEN = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [OP_LEN-1:0] opcode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  final_sum;
    logic              cout;
    logic              negative_flag;
    logic              overflow_flag;
    logic              zero_flag;
    logic              illegal_op;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, final_sum, cout, negative_flag,
               overflow_flag, zero_flag, illegal_op
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, final_sum, cout, negative_flag,
               overflow_flag, zero_flag, illegal_op
    );
endinterface

// File: rtl/alu_pipe_hs.sv
// Two-stage valid/ready pipelined ALU (operand register -> compute -> result register).
// Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe_hs #(
    parameter int WIDTH  = 32,
    parameter int OP_LEN = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_pipe_hs_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [OP_LEN-1:0] OP_ADD  = OP_LEN'(1);
    localparam logic [OP_LEN-1:0] OP_SUB  = OP_LEN'(2);
    localparam logic [OP_LEN-1:0] OP_AND  = OP_LEN'(3);
    localparam logic [OP_LEN-1:0] OP_OR   = OP_LEN'(4);
    localparam logic [OP_LEN-1:0] OP_XOR  = OP_LEN'(5);
    localparam logic [OP_LEN-1:0] OP_SLL  = OP_LEN'(6);
    localparam logic [OP_LEN-1:0] OP_SRL  = OP_LEN'(7);
    localparam logic [OP_LEN-1:0] OP_SRA  = OP_LEN'(8);
    localparam logic [OP_LEN-1:0] OP_SLT  = OP_LEN'(9);
    localparam logic [OP_LEN-1:0] OP_SLTU = OP_LEN'(10);

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [OP_LEN-1:0] op;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             neg;
        logic             ovf;
        logic             zero;
        logic             ill;
    } rsp_t;

    req_t s1_q;
    rsp_t s2_q;
    rsp_t alu_d;
    logic s1_valid;
    logic s2_valid;
    logic s2_load;
    logic accept;

    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   arith;
    logic             arith_ovf;
    logic [SH_W-1:0]  shamt;

    assign s2_load      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    // One shared adder: SUB and both compares use a + ~b + 1, whose carry is the no-borrow bit.
    assign sub_op    = (s1_q.op == OP_SUB) || (s1_q.op == OP_SLT) || (s1_q.op == OP_SLTU);
    assign b_eff     = sub_op ? ~s1_q.b : s1_q.b;
    assign arith     = {1'b0, s1_q.a} + {1'b0, b_eff} + (WIDTH+1)'(sub_op);
    assign arith_ovf = (s1_q.a[WIDTH-1] == b_eff[WIDTH-1]) && (arith[WIDTH-1] != s1_q.a[WIDTH-1]);
    assign shamt     = s1_q.b[SH_W-1:0];

    always_comb begin
        alu_d = '0;
        unique case (s1_q.op)
            OP_ADD, OP_SUB: begin
                alu_d.sum  = arith[WIDTH-1:0];
                alu_d.cout = arith[WIDTH];
                alu_d.ovf  = arith_ovf;
`ifdef ALU_SAT_EN
                // Clamp toward the sign of A: both effective operands share it on overflow.
                if (arith_ovf)
                    alu_d.sum = {s1_q.a[WIDTH-1], {(WIDTH-1){~s1_q.a[WIDTH-1]}}};
`endif
            end
            OP_AND:  alu_d.sum = s1_q.a & s1_q.b;
            OP_OR:   alu_d.sum = s1_q.a | s1_q.b;
            OP_XOR:  alu_d.sum = s1_q.a ^ s1_q.b;
            OP_SLL:  alu_d.sum = s1_q.a << shamt;
            OP_SRL:  alu_d.sum = s1_q.a >> shamt;
            OP_SRA:  alu_d.sum = WIDTH'($signed(s1_q.a) >>> shamt);
            OP_SLT: begin
                alu_d.sum  = WIDTH'($signed(s1_q.a) < $signed(s1_q.b));
                alu_d.cout = arith[WIDTH];
            end
            OP_SLTU: begin
                alu_d.sum  = WIDTH'(s1_q.a < s1_q.b);
                alu_d.cout = arith[WIDTH];
            end
            default: alu_d.ill = 1'b1;
        endcase
        alu_d.neg  = alu_d.sum[WIDTH-1];
        alu_d.zero = (alu_d.sum == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_q     <= '{a: bus.a, b: bus.b, op: bus.opcode};
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 contents only change on a load with S1 occupied, so a stalled result is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_q <= alu_d;
        end
    end

    assign bus.out_valid     = s2_valid;
    assign bus.final_sum     = s2_q.sum;
    assign bus.cout          = s2_q.cout;
    assign bus.negative_flag = s2_q.neg;
    assign bus.overflow_flag = s2_q.ovf;
    assign bus.zero_flag     = s2_q.zero;
    assign bus.illegal_op    = s2_q.ill;
endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs (WIDTH=32): directed vectors, backpressure, reset and random streaming.
module tb_alu_pipe_hs;
    logic clk;
    logic rst_n;
    int   tests_run = 0;
    int   fails     = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        neg;
        logic        ovf;
        logic        zero;
        logic        ill;
    } res_t;

    alu_pipe_hs_if #(.WIDTH(32), .OP_LEN(5)) bus ();

    alu_pipe_hs #(.WIDTH(32), .OP_LEN(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic res_t observe();
        return {bus.final_sum, bus.cout, bus.negative_flag, bus.overflow_flag,
                bus.zero_flag, bus.illegal_op};
    endfunction

    // Reference: exact integer arithmetic on 64-bit values, flags from range checks.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        res_t   r;
        longint sa, sb, s, ua, ub;
        longint max_s, min_s;
        int     sh;
        r     = '0;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = longint'(a);
        ub    = longint'(b);
        max_s = 64'sd2147483647;
        min_s = -64'sd2147483648;
        sh    = int'(b[4:0]);
        s     = 0;
        case (op)
            5'd1, 5'd2: begin
                s      = (op == 5'd1) ? sa + sb : sa - sb;
                r.sum  = s[31:0];
                r.cout = (op == 5'd1) ? (ua + ub > 64'hFFFF_FFFF) : (ua >= ub);
                r.ovf  = (s > max_s) || (s < min_s);
`ifdef ALU_SAT_EN
                if (r.ovf) r.sum = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
            end
            5'd3:  r.sum = a & b;
            5'd4:  r.sum = a | b;
            5'd5:  r.sum = a ^ b;
            5'd6:  r.sum = a << sh;
            5'd7:  r.sum = a >> sh;
            5'd8:  begin s = sa >>> sh; r.sum = s[31:0]; end
            5'd9:  begin r.sum = {31'b0, sa < sb}; r.cout = ua >= ub; end
            5'd10: begin r.sum = {31'b0, ua < ub}; r.cout = ua >= ub; end
            default: r.ill = 1'b1;
        endcase
        r.neg  = r.sum[31];
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] rand_op();
        logic [4:0] op;
        if ($urandom_range(0, 9) == 0) op = 5'($urandom);
        else op = 5'($urandom_range(1, 10));
        return op;
    endfunction

    // Issue one op into an idle pipe with out_ready high; lat counts negedges after the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          output res_t obs, output int lat);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.opcode = op; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        obs = 'x;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                obs = observe();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.opcode = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || observe() !== res_t'(0) || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b outputs=%h in_ready=%b, want 0/0/1",
                     bus.out_valid, observe(), bus.in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] a, b;
        logic [4:0]  op;
        res_t        e, obs;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: begin a = 32'd12;        b = 32'd13;        op = 5'd1;  e = {32'd25, 5'b00000}; end
                1: begin a = 32'hFFFF_FFF4; b = 32'd1;         op = 5'd2;  e = {32'hFFFF_FFF3, 5'b11000}; end
                2: begin a = 32'd12;        b = 32'hFFFF_FFFF; op = 5'd2;  e = {32'd13, 5'b00000}; end
`ifdef ALU_SAT_EN
                3: begin a = 32'h7FFF_FFFF; b = 32'd1;         op = 5'd1;  e = {32'h7FFF_FFFF, 5'b00100}; end
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = 5'd1;  e = {32'h8000_0000, 5'b11100}; end
`else
                3: begin a = 32'h7FFF_FFFF; b = 32'd1;         op = 5'd1;  e = {32'h8000_0000, 5'b01100}; end
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = 5'd1;  e = {32'h7FFF_FFFF, 5'b10100}; end
`endif
                5: begin a = 32'hFFFF_FFFF; b = 32'd0;         op = 5'd9;  e = {32'd1, 5'b10000}; end
                6: begin a = 32'hFFFF_FFFF; b = 32'd0;         op = 5'd10; e = {32'd0, 5'b10010}; end
                7: begin a = 32'h8000_0000; b = 32'd4;         op = 5'd8;  e = {32'hF800_0000, 5'b01000}; end
                8: begin a = 32'd5;         b = 32'd7;         op = 5'd31; e = {32'd0, 5'b00011}; end
                default: begin a = 32'd9;   b = 32'd3;         op = 5'd0;  e = {32'd0, 5'b00011}; end
            endcase
            run_op(a, b, op, obs, lat);
            tests_run++;
            if (obs !== e) begin
                fails++;
                $display("FAIL directed_%0d op=%0d a=%h b=%h: got {sum,c,n,v,z,ill}=%h want %h",
                         i, op, a, b, obs, e);
            end
            if (i == 0) begin
                tests_run++;
                if (lat !== 2) begin
                    fails++;
                    $display("FAIL latency: out_valid seen at negedge %0d after accept, want 2", lat);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        bit          sent3;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.opcode = 5'd1; bus.a = 32'd1; bus.b = 32'd1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.a = 32'd2; bus.b = 32'd2;
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_second_accept: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.a = 32'd3; bus.b = 32'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.final_sum !== 32'd2) begin
                fails++;
                $display("FAIL bp_stall_%0d: in_ready=%b out_valid=%b sum=%0d want 0/1/2",
                         i, bus.in_ready, bus.out_valid, bus.final_sum);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        sent3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) got.push_back(bus.final_sum);
            if (bus.in_valid && bus.in_ready) sent3 = 1'b1;
            @(posedge clk); #1;
            if (sent3) bus.in_valid = 1'b0;
        end
        tests_run++;
        if (got.size() != 3) begin
            fails++;
            $display("FAIL bp_count: %0d results drained, want 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (got[k] !== 32'(2 * (k + 1))) begin
                    fails++;
                    $display("FAIL bp_order_%0d: got %0d want %0d", k, got[k], 2 * (k + 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        res_t obs;
        int   lat;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.opcode = 5'd1; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.a = 32'd6; bus.b = 32'd6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_precond: out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || observe() !== res_t'(0) || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: out_valid=%b outputs=%h in_ready=%b want 0/0/1",
                     bus.out_valid, observe(), bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_discard: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        run_op(32'd12, 32'd13, 5'd1, obs, lat);
        tests_run++;
        if (obs.sum !== 32'd25) begin
            fails++;
            $display("FAIL rst_recover: sum=%0d want 25", obs.sum);
        end
    endtask

    // First 30 cycles run at full throughput; the rest randomize both valid and ready.
    task automatic test_stream();
        res_t q[$];
        res_t obs, exp, held;
        bit   stalled;
        int   accepts;
        stalled = 1'b0;
        accepts = 0;
        held    = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 30) begin
                bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            end else begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end
            bus.a = rand_opnd(); bus.b = rand_opnd(); bus.opcode = rand_op();
            @(negedge clk);
            obs = observe();
            if (cyc < 30 && bus.in_ready) accepts++;
            if (stalled) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || obs !== held) begin
                    fails++;
                    $display("FAIL stall_hold cyc %0d: out_valid=%b outputs=%h want 1/%h",
                             cyc, bus.out_valid, obs, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra cyc %0d: unexpected result %h", cyc, obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        fails++;
                        $display("FAIL stream_result cyc %0d: got %h want %h", cyc, obs, exp);
                    end
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = obs;
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.opcode));
        end
        tests_run++;
        if (accepts != 30) begin
            fails++;
            $display("FAIL back_to_back: %0d accepts in 30 cycles, want 30", accepts);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                obs = observe();
                tests_run++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL drain_extra: unexpected result %h", obs);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        fails++;
                        $display("FAIL drain_result: got %h want %h", obs, exp);
                    end
                end
            end
        end
        tests_run++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: %0d results missing, out_valid=%b", q.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_stall();
        test_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
